// File: rtl/store_rs_queue.sv
// Store reservation station: holds store ops until value/base operands resolve from the CDB,
// then issues the oldest ready op (data, address, byte mask) through a registered output stage.
module store_rs_queue #(
  parameter int unsigned      DEPTH   = 4,
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      TAG_W   = 6,
  parameter int unsigned      NUM_CDB = 2,
  parameter logic [TAG_W-1:0] NO_TAG  = TAG_W'(16)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [2:0]                  alloc_subtype,
  input  logic [TAG_W-1:0]            alloc_rob,
  input  logic [DATA_W-1:0]           alloc_val,
  input  logic [TAG_W-1:0]            alloc_val_tag,
  input  logic [DATA_W-1:0]           alloc_base,
  input  logic [TAG_W-1:0]            alloc_base_tag,
  input  logic [DATA_W-1:0]           alloc_offset,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [TAG_W-1:0]            issue_rob,
  output logic [DATA_W-1:0]           issue_data,
  output logic [DATA_W-1:0]           issue_addr,
  output logic [3:0]                  issue_mask,
  output logic                        issue_misalign,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [2:0]  SUB_SB = 3'b000;
  localparam logic [2:0]  SUB_SH = 3'b001;
  localparam logic [2:0]  SUB_SW = 3'b010;

  typedef struct packed {
    logic [2:0]        sub;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  val_tag;
    logic [DATA_W-1:0] base;
    logic [TAG_W-1:0]  base_tag;
    logic [DATA_W-1:0] offset;
  } entry_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  entry_t            ent_q   [DEPTH];
  entry_t            ent_d   [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH];  // older_q[i][j]: entry i is older than entry j
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              alloc_ready_q, alloc_ready_d;
  logic              issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0]  issue_rob_q, issue_rob_d;
  logic [DATA_W-1:0] issue_data_q, issue_data_d;
  logic [DATA_W-1:0] issue_addr_q, issue_addr_d;
  logic [3:0]        issue_mask_q, issue_mask_d;
  logic              issue_mis_q, issue_mis_d;

  logic [DEPTH-1:0]  rdy_c, pick_c;
  logic [IDX_W-1:0]  pick_idx_c, free_idx_c;
  entry_t            pick_ent_c;
  logic [DATA_W-1:0] pick_addr_c;
  logic [3:0]        pick_mask_c;
  logic              pick_mis_c;
  logic              issue_load_c, issue_fire_c, alloc_fire_c;

  // Operand wakeup: lowest matching CDB port wins; NO_TAG never matches.
  function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0] tag,
                                                   input logic [DATA_W-1:0] data);
    logic hit;
    hit  = 1'b0;
    wake = {tag, data};
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      if (!hit && cdb_valid[k] && tag != NO_TAG && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
        hit  = 1'b1;
        wake = {NO_TAG, cdb_data[k*DATA_W +: DATA_W]};
      end
    end
  endfunction

  // Oldest-ready pick, lowest free slot, and store shaping of the picked entry.
  always_comb begin
    rdy_c      = '0;
    pick_c     = '0;
    pick_idx_c = '0;
    pick_ent_c = '0;
    free_idx_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rdy_c[i] = valid_q[i] && ent_q[i].val_tag == NO_TAG && ent_q[i].base_tag == NO_TAG;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      pick_c[i] = rdy_c[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (rdy_c[j] && older_q[j][i]) pick_c[i] = 1'b0;
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = IDX_W'(i);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (pick_c[i]) begin
        pick_idx_c = IDX_W'(i);
        pick_ent_c = ent_q[i];
      end
    end
    pick_addr_c = pick_ent_c.base + pick_ent_c.offset;
    case (pick_ent_c.sub)
      SUB_SB: begin
        pick_mask_c = 4'b0001 << pick_addr_c[1:0];
        pick_mis_c  = 1'b0;
      end
      SUB_SH: begin
        pick_mask_c = 4'b0011 << {pick_addr_c[1], 1'b0};
        pick_mis_c  = pick_addr_c[0];
      end
      SUB_SW: begin
        pick_mask_c = 4'b1111;
        pick_mis_c  = |pick_addr_c[1:0];
      end
      default: begin
        pick_mask_c = 4'b0000;
        pick_mis_c  = 1'b1;
      end
    endcase
    issue_load_c = !issue_valid_q || issue_ready;
    issue_fire_c = issue_load_c && (|rdy_c);
    alloc_fire_c = alloc_valid && alloc_ready_q;
  end

  // Next state: wakeup, dequeue, allocate, output stage, flush last.
  always_comb begin
    valid_d       = valid_q;
    older_d       = older_q;
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    issue_rob_d   = issue_rob_q;
    issue_data_d  = issue_data_q;
    issue_addr_d  = issue_addr_q;
    issue_mask_d  = issue_mask_q;
    issue_mis_d   = issue_mis_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = ent_q[i];
      {ent_d[i].val_tag, ent_d[i].val}   = wake(ent_q[i].val_tag, ent_q[i].val);
      {ent_d[i].base_tag, ent_d[i].base} = wake(ent_q[i].base_tag, ent_q[i].base);
    end
    if (issue_fire_c) valid_d[pick_idx_c] = 1'b0;
    if (alloc_fire_c) begin
      valid_d[free_idx_c]      = 1'b1;
      ent_d[free_idx_c].sub    = alloc_subtype;
      ent_d[free_idx_c].rob    = alloc_rob;
      ent_d[free_idx_c].offset = alloc_offset;
      {ent_d[free_idx_c].val_tag, ent_d[free_idx_c].val}   = wake(alloc_val_tag, alloc_val);
      {ent_d[free_idx_c].base_tag, ent_d[free_idx_c].base} = wake(alloc_base_tag, alloc_base);
      older_d[free_idx_c] = '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (IDX_W'(j) != free_idx_c) older_d[j][free_idx_c] = 1'b1;
      end
    end
    count_d = count_q + CNT_W'(alloc_fire_c) - CNT_W'(issue_fire_c);
    if (issue_load_c) begin
      issue_valid_d = |rdy_c;
      if (|rdy_c) begin
        issue_rob_d  = pick_ent_c.rob;
        issue_data_d = pick_ent_c.val;
        issue_addr_d = pick_addr_c;
        issue_mask_d = pick_mask_c;
        issue_mis_d  = pick_mis_c;
      end
    end
    if (flush) begin
      valid_d       = '0;
      count_d       = '0;
      issue_valid_d = 1'b0;
    end
    alloc_ready_d = count_d != CNT_W'(DEPTH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      count_q       <= '0;
      alloc_ready_q <= 1'b1;
      issue_valid_q <= 1'b0;
      issue_rob_q   <= '0;
      issue_data_q  <= '0;
      issue_addr_q  <= '0;
      issue_mask_q  <= '0;
      issue_mis_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      count_q       <= count_d;
      alloc_ready_q <= alloc_ready_d;
      issue_valid_q <= issue_valid_d;
      issue_rob_q   <= issue_rob_d;
      issue_data_q  <= issue_data_d;
      issue_addr_q  <= issue_addr_d;
      issue_mask_q  <= issue_mask_d;
      issue_mis_q   <= issue_mis_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  assign alloc_ready    = alloc_ready_q;
  assign count          = count_q;
  assign issue_valid    = issue_valid_q;
  assign issue_rob      = issue_rob_q;
  assign issue_data     = issue_data_q;
  assign issue_addr     = issue_addr_q;
  assign issue_mask     = issue_mask_q;
  assign issue_misalign = issue_mis_q;

endmodule

// File: tb/tb_store_rs_queue.sv
// Bench for store_rs_queue: directed scenarios with literal expectations, then random traffic
// checked every cycle against an age-ordered queue model of the reservation station.
module tb_store_rs_queue;

  localparam int DEPTH  = 4;
  localparam int NO_TAG = 16;

  logic        clock = 1'b0;
  logic        reset, flush, alloc_valid, alloc_ready;
  logic [2:0]  alloc_subtype;
  logic [5:0]  alloc_rob, alloc_val_tag, alloc_base_tag;
  logic [31:0] alloc_val, alloc_base, alloc_offset;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid, issue_ready, issue_misalign;
  logic [5:0]  issue_rob;
  logic [31:0] issue_data, issue_addr;
  logic [3:0]  issue_mask;
  logic [2:0]  count;
  logic [5:0]  ct [2];
  logic [31:0] cd [2];

  assign cdb_tag  = {ct[1], ct[0]};
  assign cdb_data = {cd[1], cd[0]};

  store_rs_queue dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_subtype(alloc_subtype),
    .alloc_rob(alloc_rob), .alloc_val(alloc_val), .alloc_val_tag(alloc_val_tag),
    .alloc_base(alloc_base), .alloc_base_tag(alloc_base_tag), .alloc_offset(alloc_offset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob(issue_rob),
    .issue_data(issue_data), .issue_addr(issue_addr), .issue_mask(issue_mask),
    .issue_misalign(issue_misalign), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  sub;
    logic [5:0]  rob;
    logic [31:0] val;
    logic [5:0]  vt;
    logic [31:0] base;
    logic [5:0]  bt;
    logic [31:0] off;
  } op_t;

  // Model: waiting ops oldest-first, plus the output register contents.
  op_t         mq[$];
  op_t         n_q[$];
  logic        m_ov, n_ov;
  logic [5:0]  m_rob, n_rob;
  logic [31:0] m_data, n_data, m_addr, n_addr;
  logic [3:0]  m_mask, n_mask;
  logic        m_mis, n_mis;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] wake(input logic [5:0] tag, input logic [31:0] data);
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k] && tag != 6'(NO_TAG) && ct[k] == tag) return {6'(NO_TAG), cd[k]};
    end
    return {tag, data};
  endfunction

  function automatic void shape(input logic [2:0] sub, input logic [31:0] a,
                                output logic [3:0] mk, output logic mis);
    int lane;
    lane = int'(a % 4);
    case (sub)
      3'd0: begin mk = 4'(1 << lane); mis = 1'b0; end
      3'd1: begin mk = (lane >= 2) ? 4'b1100 : 4'b0011; mis = (a % 2) != 0; end
      3'd2: begin mk = 4'b1111; mis = lane != 0; end
      default: begin mk = 4'b0000; mis = 1'b1; end
    endcase
  endfunction

  task automatic model_step();
    op_t o;
    logic [37:0] r;
    n_q = mq;
    n_ov = m_ov; n_rob = m_rob; n_data = m_data; n_addr = m_addr; n_mask = m_mask; n_mis = m_mis;
    if (!m_ov || issue_ready) begin
      n_ov = 1'b0;
      for (int i = 0; i < n_q.size(); i++) begin
        if (n_q[i].vt == 6'(NO_TAG) && n_q[i].bt == 6'(NO_TAG)) begin
          n_ov   = 1'b1;
          n_rob  = n_q[i].rob;
          n_data = n_q[i].val;
          n_addr = n_q[i].base + n_q[i].off;
          shape(n_q[i].sub, n_addr, n_mask, n_mis);
          n_q.delete(i);
          break;
        end
      end
    end
    for (int i = 0; i < n_q.size(); i++) begin
      o = n_q[i];
      r = wake(o.vt, o.val);  o.vt = r[37:32]; o.val  = r[31:0];
      r = wake(o.bt, o.base); o.bt = r[37:32]; o.base = r[31:0];
      n_q[i] = o;
    end
    if (alloc_valid && mq.size() < DEPTH) begin
      o.sub = alloc_subtype; o.rob = alloc_rob; o.off = alloc_offset;
      r = wake(alloc_val_tag, alloc_val);   o.vt = r[37:32]; o.val  = r[31:0];
      r = wake(alloc_base_tag, alloc_base); o.bt = r[37:32]; o.base = r[31:0];
      n_q.push_back(o);
    end
    if (flush) begin
      n_q.delete();
      n_ov = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    mq = n_q;
    m_ov = n_ov; m_rob = n_rob; m_data = n_data; m_addr = n_addr; m_mask = n_mask; m_mis = n_mis;
    @(negedge clock);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
      check("count", 32'(count), 32'(mq.size()));
      check("issue_valid", 32'(issue_valid), 32'(m_ov));
      if (m_ov) begin
        check("issue_rob", 32'(issue_rob), 32'(m_rob));
        check("issue_data", issue_data, m_data);
        check("issue_addr", issue_addr, m_addr);
        check("issue_mask", 32'(issue_mask), 32'(m_mask));
        check("issue_misalign", 32'(issue_misalign), 32'(m_mis));
      end
    end
  end

  task automatic idle();
    alloc_valid = 1'b0; flush = 1'b0; cdb_valid = 2'b00;
  endtask

  task automatic set_alloc(input logic [2:0] sub, input logic [5:0] rob, input logic [31:0] val,
                           input logic [5:0] vt, input logic [31:0] base, input logic [5:0] bt,
                           input logic [31:0] off);
    alloc_valid = 1'b1; alloc_subtype = sub; alloc_rob = rob; alloc_val = val;
    alloc_val_tag = vt; alloc_base = base; alloc_base_tag = bt; alloc_offset = off;
  endtask

  task automatic wait_issue(input int max);
    for (int i = 0; i < max && !issue_valid; i++) tick();
    check("wait_issue", 32'(issue_valid), 32'd1);
  endtask

  task automatic drain(input int n);
    idle();
    issue_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    issue_ready = 1'b0;
  endtask

  function automatic logic [31:0] rtag();
    return ($urandom_range(0, 1) == 0) ? 32'(NO_TAG) : 32'($urandom_range(1, 7));
  endfunction

  initial begin
    logic [5:0] got[$];
    reset = 1'b1; issue_ready = 1'b0;
    idle();
    set_alloc(3'd0, 6'd0, 32'd0, 6'(NO_TAG), 32'd0, 6'(NO_TAG), 32'd0);
    alloc_valid = 1'b0;
    ct[0] = '0; ct[1] = '0; cd[0] = '0; cd[1] = '0;
    mq.delete();
    m_ov = 1'b0; m_rob = '0; m_data = '0; m_addr = '0; m_mask = '0; m_mis = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_data", issue_data, 32'd0);
    check("rst_addr", issue_addr, 32'd0);
    check("rst_mask_mis", 32'({issue_mask, issue_misalign}), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Ready SW alloc
    set_alloc(3'b010, 6'd3, 32'h1122_3344, 6'(NO_TAG), 32'h1000, 6'(NO_TAG), 32'd8);
    tick(); idle();
    wait_issue(4);
    check("sw_addr", issue_addr, 32'h1008);
    check("sw_mask", 32'(issue_mask), 32'hF);
    check("sw_rob", 32'(issue_rob), 32'd3);
    check("sw_data", issue_data, 32'h1122_3344);
    drain(2);

    // SB waiting on base tag 5, woken by port 1
    set_alloc(3'b000, 6'd9, 32'h55, 6'(NO_TAG), 32'h0, 6'd5, 32'h3);
    tick(); idle();
    cdb_valid = 2'b10; ct[1] = 6'd5; cd[1] = 32'h2000;
    tick(); idle();
    wait_issue(4);
    check("wake_addr", issue_addr, 32'h2003);
    check("wake_mask", 32'(issue_mask), 32'b1000);
    drain(2);

    // Same-cycle bypass; both ports carry tag 7, port 0 must win
    set_alloc(3'b010, 6'd12, 32'h0, 6'd7, 32'h3000, 6'(NO_TAG), 32'h0);
    cdb_valid = 2'b11; ct[0] = 6'd7; cd[0] = 32'hAB; ct[1] = 6'd7; cd[1] = 32'hCD;
    tick(); idle();
    wait_issue(4);
    check("bypass_data", issue_data, 32'hAB);
    drain(2);

    // Age order
    set_alloc(3'b010, 6'd1, 32'h1, 6'(NO_TAG), 32'h100, 6'd9, 32'h0);  tick();
    set_alloc(3'b010, 6'd2, 32'h2, 6'(NO_TAG), 32'h200, 6'd10, 32'h0); tick();
    set_alloc(3'b010, 6'd3, 32'h3, 6'(NO_TAG), 32'h300, 6'(NO_TAG), 32'h0); tick();
    set_alloc(3'b010, 6'd4, 32'h4, 6'(NO_TAG), 32'h400, 6'(NO_TAG), 32'h0); tick();
    idle();
    wait_issue(4);
    check("age_first", 32'(issue_rob), 32'd3);
    issue_ready = 1'b1;
    tick();
    check("age_second", 32'({issue_valid, issue_rob}), 32'({1'b1, 6'd4}));
    set_alloc(3'b010, 6'd5, 32'h5, 6'(NO_TAG), 32'h500, 6'(NO_TAG), 32'h0);
    cdb_valid = 2'b01; ct[0] = 6'd9; cd[0] = 32'h900;
    tick(); idle();
    issue_ready = 1'b0;
    wait_issue(4);
    check("age_woken_first", 32'(issue_rob), 32'd1);
    cdb_valid = 2'b01; ct[0] = 6'd10; cd[0] = 32'hA00;
    tick();
    drain(8);
    check("age_empty", 32'(count), 32'd0);

    // Full and backpressure
    set_alloc(3'b010, 6'd10, 32'h10, 6'(NO_TAG), 32'h10, 6'(NO_TAG), 32'h0); tick();
    for (int r = 11; r <= 14; r++) begin
      set_alloc(3'b010, 6'(r), 32'(r), 6'd20, 32'(r * 16), 6'(NO_TAG), 32'h0); tick();
    end
    set_alloc(3'b010, 6'd15, 32'h15, 6'(NO_TAG), 32'h150, 6'(NO_TAG), 32'h0); tick();
    idle();
    check("full_count", 32'(count), 32'd4);
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_hold_rob", 32'(issue_rob), 32'd10);
    tick(); tick();
    check("full_hold_rob2", 32'({issue_valid, issue_rob}), 32'({1'b1, 6'd10}));
    issue_ready = 1'b1;
    cdb_valid = 2'b01; ct[0] = 6'd20; cd[0] = 32'h77;
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) got.push_back(issue_rob);
      tick(); idle();
    end
    check("drain_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++) check("drain_order", 32'(got[i]), 32'(10 + i));
    issue_ready = 1'b0;

    // Flush drops the same-cycle alloc and CDB capture
    set_alloc(3'b010, 6'd20, 32'h20, 6'(NO_TAG), 32'h20, 6'(NO_TAG), 32'h0); tick();
    for (int r = 21; r <= 23; r++) begin
      set_alloc(3'b000, 6'(r), 32'(r), 6'(NO_TAG), 32'(r), 6'd21, 32'h0); tick();
    end
    idle();
    check("pre_flush", 32'({issue_valid, count}), 32'({1'b1, 3'd3}));
    flush = 1'b1;
    set_alloc(3'b010, 6'd24, 32'h24, 6'(NO_TAG), 32'h24, 6'(NO_TAG), 32'h0);
    cdb_valid = 2'b01; ct[0] = 6'd21; cd[0] = 32'h99;
    tick(); idle();
    check("flush_now", 32'({issue_valid, alloc_ready, count}), 32'({1'b0, 1'b1, 3'd0}));
    tick(); tick();
    check("flush_after", 32'({issue_valid, count}), 32'd0);

    // Asynchronous reset mid-cycle
    set_alloc(3'b010, 6'd30, 32'hDEAD, 6'(NO_TAG), 32'h30, 6'(NO_TAG), 32'h4); tick();
    set_alloc(3'b010, 6'd31, 32'h31, 6'd9, 32'h31, 6'(NO_TAG), 32'h0); tick();
    idle(); tick();
    check("pre_reset", 32'({issue_valid, count}), 32'({1'b1, 3'd1}));
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_valid_count", 32'({issue_valid, count}), 32'd0);
    check("async_addr", issue_addr, 32'd0);
    check("async_data", issue_data, 32'd0);
    check("async_ready", 32'(alloc_ready), 32'd1);
    mq.delete();
    m_ov = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      alloc_valid = $urandom_range(0, 9) < 6;
      alloc_subtype = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      alloc_rob = 6'($urandom_range(0, 63));
      alloc_val = $urandom;
      alloc_base = $urandom;
      alloc_offset = $urandom;
      alloc_val_tag = 6'(rtag());
      alloc_base_tag = 6'(rtag());
      cdb_valid = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        ct[k] = ($urandom_range(0, 7) == 0) ? 6'(NO_TAG) : 6'($urandom_range(1, 7));
        cd[k] = $urandom;
      end
      issue_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) < 2;
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
